fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly downstream of the program pointer register.
- Consumes the pointer's current value as the fetch address and issues a held-request read to instruction memory.
- Presents the returned word to decode through a valid/ready handshake.
- Drives the pointer's set/update/val inputs: +1 after each successful fetch, or an absolute/relative redirect from the branch logic, discarding any fetch made stale by that redirect.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads instruction memory at the current program
// pointer, hands the word to decode over valid/ready, and steers the pointer
// (+1 after a fetch, absolute/relative on a branch redirect).
module fetch_unit #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pc_val,
  output logic                 pc_set,
  output logic                 pc_update,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_req,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic                 redirect_abs,
  input  logic [WORD_SIZE-1:0] redirect_val
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    FLUSH   = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t state;

  // Redirects are meaningless while the block is held in reset.
  logic redir;
  assign redir = redirect & ~reset;

  // The fetch address always tracks the pointer; in FLUSH memory ignores it
  // until the stale read completes.
  assign mem_addr = pc;

  // A read is outstanding in REQ (new fetch) and FLUSH (stale fetch draining).
  assign mem_req = ~reset & ((state == REQ) | (state == FLUSH));

  // Pointer control: redirect wins over the increment; the increment only
  // happens on a clean completion in REQ.
  always_comb begin
    pc_set    = 1'b0;
    pc_update = 1'b0;
    pc_val    = '0;
    if (!reset) begin
      if (redir) begin
        pc_set    = redirect_abs;
        pc_update = ~redirect_abs;
        pc_val    = redirect_val;
      end else if (state == REQ && mem_ready) begin
        pc_update = 1'b1;
        pc_val    = ONE;
      end
    end
  end

  // Fetch state machine and registered decode-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (mem_ready && !redir) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= DELIVER;
          end else if (!mem_ready && redir) begin
            // The in-flight read targets the old path; drain it first.
            state <= FLUSH;
          end
          // mem_ready with redirect: data dropped, re-request at new pc.
        end
        FLUSH: begin
          // The stale read ends the flush even if another redirect arrives.
          if (mem_ready) begin
            state <= REQ;
          end
        end
        DELIVER: begin
          // A redirect squashes the held word whether or not decode took it.
          if (redir || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a pointer-register model and a
// scoreboard of expected delivered instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] pc_val;
  logic        pc_set;
  logic        pc_update;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic        redirect_abs;
  logic [15:0] redirect_val;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] addr;
  } exp_t;
  exp_t exp_q[$];

  fetch_unit #(.WORD_SIZE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .pc_val       (pc_val),
    .pc_set       (pc_set),
    .pc_update    (pc_update),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_abs (redirect_abs),
    .redirect_val (redirect_val)
  );

  always #5 clk = ~clk;

  // Program pointer register driven by the fetch unit.
  always @(posedge clk or posedge reset) begin
    if (reset)          pc <= 16'h0000;
    else if (pc_set)    pc <= pc_val;
    else if (pc_update) pc <= pc + pc_val;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: each new presentation of instr_valid is popped and compared.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_instr: got %h@%h expected none", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.word);
        chk("sb_instr_pc", instr_pc, e.addr);
      end
    end
    prev_v = instr_valid & ~reset;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_rdata = 16'h0; mem_ready = 1'b0; instr_ready = 1'b1;
    redirect = 1'b1; redirect_abs = 1'b1; redirect_val = 16'h1234;
    #2;
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_pc_set", {15'd0, pc_set}, 16'd0);
    chk("rst_pc_update", {15'd0, pc_update}, 16'd0);
    chk("rst_pc_val", pc_val, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    step(); step();
    redirect = 1'b0; reset = 1'b0;
    #1;
    chk("idle_mem_req", {15'd0, mem_req}, 16'd0);
    step();

    // Zero-wait fetches at 0..3, decode always ready.
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      mem_rdata = (i == 0) ? 16'hA5A5 : 16'h1000 + 16'(i);
      #1;
      chk("req_mem_req", {15'd0, mem_req}, 16'd1);
      chk("req_addr", mem_addr, 16'(i));
      chk("req_pc_update", {15'd0, pc_update}, 16'd1);
      chk("req_pc_val", pc_val, 16'h0001);
      chk("req_valid_low", {15'd0, instr_valid}, 16'd0);
      exp_q.push_back({mem_rdata, 16'(i)});
      step();
      mem_ready = 1'b0;
      #1;
      chk("dlv_valid", {15'd0, instr_valid}, 16'd1);
      chk("dlv_mem_req", {15'd0, mem_req}, 16'd0);
      step();
    end

    // Memory waits 3 cycles at address 4.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_mem_req", {15'd0, mem_req}, 16'd1);
      chk("wait_addr", mem_addr, 16'h0004);
      chk("wait_no_update", {15'd0, pc_update}, 16'd0);
      step();
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("late_pc_update", {15'd0, pc_update}, 16'd1);
    exp_q.push_back({16'hBEEF, 16'h0004});
    step();
    mem_ready = 1'b0; instr_ready = 1'b0;
    step();
    // Decode stalled: word held.
    chk("hold_valid", {15'd0, instr_valid}, 16'd1);
    chk("hold_instr", instr, 16'hBEEF);
    chk("hold_instr_pc", instr_pc, 16'h0004);
    instr_ready = 1'b1;
    step();
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    exp_q.push_back({16'h5555, 16'h0005});
    step();

    // Relative redirect of -2 while delivering the word from 5 (pc=6).
    mem_ready = 1'b0; instr_ready = 1'b0;
    redirect = 1'b1; redirect_abs = 1'b0; redirect_val = 16'hFFFE;
    #1;
    chk("rel_pc", pc, 16'h0006);
    chk("rel_pc_update", {15'd0, pc_update}, 16'd1);
    chk("rel_pc_set", {15'd0, pc_set}, 16'd0);
    chk("rel_pc_val", pc_val, 16'hFFFE);
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    #1;
    chk("rel_squash", {15'd0, instr_valid}, 16'd0);
    chk("rel_next_addr", mem_addr, 16'h0004);

    // Absolute redirect while waiting in REQ -> FLUSH.
    redirect = 1'b1; redirect_abs = 1'b1; redirect_val = 16'h0040;
    #1;
    chk("abs_pc_set", {15'd0, pc_set}, 16'd1);
    chk("abs_pc_val", pc_val, 16'h0040);
    step();
    redirect = 1'b0;
    #1;
    chk("flush_mem_req", {15'd0, mem_req}, 16'd1);
    step();
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("stale_no_update", {15'd0, pc_update}, 16'd0);
    chk("stale_no_set", {15'd0, pc_set}, 16'd0);
    step();
    mem_ready = 1'b0;
    #1;
    chk("stale_valid", {15'd0, instr_valid}, 16'd0);
    chk("post_flush_req", {15'd0, mem_req}, 16'd1);
    chk("post_flush_addr", mem_addr, 16'h0040);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    exp_q.push_back({16'h1234, 16'h0040});
    step();
    mem_ready = 1'b0;
    step();

    // Completion and redirect in the same REQ cycle.
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    redirect = 1'b1; redirect_abs = 1'b1; redirect_val = 16'h0080;
    #1;
    chk("both_no_update", {15'd0, pc_update}, 16'd0);
    chk("both_pc_set", {15'd0, pc_set}, 16'd1);
    step();
    mem_ready = 1'b0; redirect_abs = 1'b0; redirect_val = 16'h0003;
    #1;
    chk("both_valid", {15'd0, instr_valid}, 16'd0);
    chk("both_req_addr", mem_addr, 16'h0080);
    chk("both_mem_req", {15'd0, mem_req}, 16'd1);
    step();
    // Now FLUSH; reset asynchronously mid-cycle.
    #2;
    reset = 1'b1;
    redirect = 1'b1;
    #1;
    chk("mid_rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("mid_rst_pc_update", {15'd0, pc_update}, 16'd0);
    chk("mid_rst_pc_set", {15'd0, pc_set}, 16'd0);
    chk("mid_rst_instr", instr, 16'h0000);
    chk("mid_rst_instr_pc", instr_pc, 16'h0000);
    chk("mid_rst_valid", {15'd0, instr_valid}, 16'd0);
    step();
    reset = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_to_idle", {15'd0, mem_req}, 16'd0);
    step();
    chk("restart_req", {15'd0, mem_req}, 16'd1);
    chk("restart_addr", mem_addr, 16'h0000);

    step();
    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
